// File: rtl/sm_arith_pkg.sv
// Shared widths, state encoding and sign-magnitude helpers for the
// sign-magnitude multiplier/divider pair in the arithmetic unit.
package sm_arith_pkg;

  localparam int DIVIDEND_W = 16;  // {sign, unused, mag[13:0]}
  localparam int OPERAND_W  = 8;   // {sign, mag[6:0]}
  localparam int MAG_W      = 7;
  localparam int DMAG_W     = 14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } div_state_e;

  // Sign field of an 8-bit sign-magnitude operand.
  function automatic logic sm_sign(input logic [OPERAND_W-1:0] v);
    return v[OPERAND_W-1];
  endfunction

  // Magnitude field of an 8-bit sign-magnitude operand.
  function automatic logic [MAG_W-1:0] sm_mag(input logic [OPERAND_W-1:0] v);
    return v[MAG_W-1:0];
  endfunction

  // Pack sign and magnitude; a zero magnitude is always reported as +0.
  function automatic logic [OPERAND_W-1:0] sm_pack(input logic s,
                                                   input logic [MAG_W-1:0] m);
    return {s & (m != '0), m};
  endfunction

endpackage

// File: rtl/sm_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor magnitude when it fits, and report the resulting quotient bit.
module sm_div_step
  import sm_arith_pkg::*;
(
  input  logic [OPERAND_W-1:0] rem_i,
  input  logic                 bit_i,
  input  logic [MAG_W-1:0]     dmag_i,
  output logic [OPERAND_W-1:0] rem_o,
  output logic                 q_o
);

  logic [OPERAND_W:0] shifted;

  // Trial subtraction; the remainder stays below the divisor so 8 bits suffice.
  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = 1'b0;
    rem_o   = shifted[OPERAND_W-1:0];
    if (shifted >= {2'b00, dmag_i}) begin
      q_o   = 1'b1;
      rem_o = OPERAND_W'(shifted - {2'b00, dmag_i});
    end
  end

endmodule

// File: rtl/sm_divider.sv
// Sequential sign-magnitude divider: 14 restoring steps on the dividend
// magnitude, then sign/saturation/divide-by-zero fix-up in FINISH.
// Handshake: a start seen while state is IDLE is accepted on that edge;
// busy stays high until the edge that raises done for one cycle, and the
// results plus flags hold until the next done. start outside IDLE is dropped.
module sm_divider
  import sm_arith_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [OPERAND_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [OPERAND_W-1:0]  quotient,
  output logic [OPERAND_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow,
  output div_state_e            state_dbg
);

  div_state_e             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [OPERAND_W-1:0]   rem_q, rem_d;
  logic [DMAG_W-1:0]      quo_q, quo_d;
  logic [DMAG_W:0]        dvd_q, dvd_d;
  logic                   dsign_q, dsign_d;
  logic [OPERAND_W-1:0]   dvs_q, dvs_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [OPERAND_W-1:0]   quotient_q, quotient_d;
  logic [OPERAND_W-1:0]   remainder_q, remainder_d;
  logic                   dbz_q, dbz_d;
  logic                   ovf_q, ovf_d;

  logic [OPERAND_W-1:0]   step_rem;
  logic                   step_q;
  logic                   q_sign;
  logic                   q_ovf;

  sm_div_step u_step (
    .rem_i  (rem_q),
    .bit_i  (dvd_q[cnt_q]),
    .dmag_i (sm_mag(dvs_q)),
    .rem_o  (step_rem),
    .q_o    (step_q)
  );

  // Next-state, datapath and result fix-up.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvd_d       = dvd_q;
    dsign_d     = dsign_q;
    dvs_d       = dvs_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    q_sign      = dsign_q ^ sm_sign(dvs_q);
    q_ovf       = |quo_q[DMAG_W-1:MAG_W];

    case (state_q)
      IDLE: begin
        if (start) begin
          // Bit 14 of the dividend is masked off: it carries no magnitude.
          dvd_d   = dividend[DMAG_W:0] & {1'b0, {DMAG_W{1'b1}}};
          dsign_d = dividend[DIVIDEND_W-1];
          dvs_d   = divisor;
          cnt_d   = 4'(DMAG_W - 1);
          rem_d   = '0;
          quo_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = {quo_q[DMAG_W-2:0], step_q};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) state_d = FINISH;
      end
      FINISH: begin
        if (sm_mag(dvs_q) == '0) begin
          quotient_d  = {q_sign, {MAG_W{1'b1}}};
          remainder_d = '0;
          dbz_d       = 1'b1;
          ovf_d       = 1'b0;
        end else begin
          quotient_d  = sm_pack(q_sign, q_ovf ? {MAG_W{1'b1}} : quo_q[MAG_W-1:0]);
          remainder_d = sm_pack(dsign_q, rem_q[MAG_W-1:0]);
          dbz_d       = 1'b0;
          ovf_d       = q_ovf;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvd_q       <= '0;
      dsign_q     <= 1'b0;
      dvs_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvd_q       <= dvd_d;
      dsign_q     <= dsign_d;
      dvs_q       <= dvs_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_sm_divider.sv
// Directed bench for sm_divider: hand-computed vectors, abort/reset case and
// a multiply-then-divide round trip over a spread of operands.
module tb_sm_divider;
  import sm_arith_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy, done, div_by_zero, overflow;
  logic [7:0]  quotient, remainder;
  div_state_e  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  sm_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .state_dbg   (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one division, wait (bounded) for done, check latency and results.
  task automatic run_div(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                         input logic [7:0] exp_q, input logic [7:0] exp_r,
                         input logic exp_dz, input logic exp_ov);
    int lat;
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(negedge clk);                      // just after the accepting edge E0
    start    = 1'b0;
    dividend = 16'($urandom);            // operands may change after acceptance
    divisor  = 8'($urandom);
    check({tag, " busy_after_e0"}, 16'(busy), 16'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 16'(lat), 16'd15);
    check({tag, " busy_at_done"}, 16'(busy), 16'd0);
    check({tag, " quotient"}, 16'(quotient), 16'(exp_q));
    check({tag, " remainder"}, 16'(remainder), 16'(exp_r));
    check({tag, " div_by_zero"}, 16'(div_by_zero), 16'(exp_dz));
    check({tag, " overflow"}, 16'(overflow), 16'(exp_ov));
    @(negedge clk);
    check({tag, " done_one_cycle"}, 16'(done), 16'd0);
    check({tag, " quotient_held"}, 16'(quotient), 16'(exp_q));
  endtask

  // Multiply A by B in sign-magnitude, divide back by B, expect A (+0 for -0).
  task automatic round_trip(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    logic [7:0]  exp_q;
    prod  = {a[7] ^ b[7], 1'b0, 14'(a[6:0] * b[6:0])};
    exp_q = (a[6:0] == 7'd0) ? 8'h00 : a;
    run_div($sformatf("rt_%02h_%02h", a, b), prod, b, exp_q, 8'h00, 1'b0, 1'b0);
  endtask

  logic [7:0] b_list [7] = '{8'h01, 8'h82, 8'h03, 8'h87, 8'hC0, 8'h7F, 8'hFF};

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_quotient", 16'(quotient), 16'd0);
    check("rst_remainder", 16'(remainder), 16'd0);
    check("rst_flags", 16'({div_by_zero, overflow}), 16'd0);
    check("rst_state", 16'(state_dbg), 16'(IDLE));
    rst = 1'b0;

    // Directed vectors.
    run_div("neg15_div_3",    16'h800F, 8'h03, 8'h85, 8'h00, 1'b0, 1'b0);
    run_div("100_div_neg7",   16'h0064, 8'h87, 8'h8E, 8'h02, 1'b0, 1'b0);
    run_div("neg100_div_7",   16'h8064, 8'h07, 8'h8E, 8'h82, 1'b0, 1'b0);
    run_div("neg0_div_5",     16'h8000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0);
    run_div("div_by_zero",    16'h0010, 8'h80, 8'hFF, 8'h00, 1'b1, 1'b0);
    run_div("div_by_pos_zero",16'h8010, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0);
    run_div("bit14_ignored",  16'h4064, 8'h05, 8'h14, 8'h00, 1'b0, 1'b0);
    run_div("overflow",       16'h3F01, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b1);
    run_div("max_no_ovf",     16'h3F01, 8'h7F, 8'h7F, 8'h00, 1'b0, 1'b0);

    // Abort: second start at E3 is dropped, rst at E7 clears everything.
    @(negedge clk);
    dividend = 16'h0064;
    divisor  = 8'h05;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);                    // just after edge Ek
      check($sformatf("abort_no_done_e%0d", k), 16'(done), 16'd0);
      if (k == 2) start = 1'b1;
      if (k == 3) start = 1'b0;
      if (k == 6) begin
        check("abort_busy_e6", 16'(busy), 16'd1);
        rst = 1'b1;
      end
      if (k == 7) begin
        rst = 1'b0;
        check("abort_busy", 16'(busy), 16'd0);
        check("abort_quotient", 16'(quotient), 16'd0);
        check("abort_remainder", 16'(remainder), 16'd0);
        check("abort_flags", 16'({div_by_zero, overflow}), 16'd0);
        check("abort_state", 16'(state_dbg), 16'(IDLE));
      end
    end
    run_div("fresh_after_abort", 16'h0064, 8'h05, 8'h14, 8'h00, 1'b0, 1'b0);

    // Round trip through the multiplier format.
    for (int ai = 0; ai < 256; ai += 17) begin
      for (int bi = 0; bi < 7; bi++) round_trip(8'(ai), b_list[bi]);
    end
    for (int bi = 0; bi < 7; bi++) round_trip(8'h80, b_list[bi]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
